// File: rtl/nibble_serial_adder_ctrl.sv
// Wide unsigned adder that reuses one 4-bit ripple slice, one nibble per clock, LSB first.
// Operands are captured on an accepted start; the result appears with a one-cycle done pulse.

module nibble_add4 (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic       cin_i,
   output logic [3:0] sum_o,
   output logic       cout_o
);
   logic [4:0] carry;

   assign carry[0] = cin_i;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_bit
         assign sum_o[gi]     = a_i[gi] ^ b_i[gi] ^ carry[gi];
         assign carry[gi + 1] = (a_i[gi] & b_i[gi]) | (carry[gi] & (a_i[gi] ^ b_i[gi]));
      end
   endgenerate

   assign cout_o = carry[4];
endmodule

module nibble_serial_adder_ctrl #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   start_i,
   input  logic [4*NIBBLES-1:0]   a_i,
   input  logic [4*NIBBLES-1:0]   b_i,
   input  logic                   cin_i,
   output logic                   ready_o,
   output logic                   busy_o,
   output logic                   done_o,
   output logic [4*NIBBLES-1:0]   sum_o,
   output logic                   cout_o
);
   localparam int W  = 4 * NIBBLES;
   localparam int IW = ($clog2(NIBBLES + 1) < 1) ? 1 : $clog2(NIBBLES + 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    opa_q, opa_d;
   logic [W-1:0]    opb_q, opb_d;
   logic            c_q, c_d;
   logic [W-1:0]    acc_q, acc_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [W-1:0]    sum_q, sum_d;
   logic            cout_q, cout_d;

   logic [3:0]      slice_sum;
   logic            slice_cout;
   logic [W-1:0]    acc_run;

   nibble_add4 u_slice (
      .a_i    (opa_q[3:0]),
      .b_i    (opb_q[3:0]),
      .cin_i  (c_q),
      .sum_o  (slice_sum),
      .cout_o (slice_cout)
   );

   // Accumulator image with the current slice result dropped into nibble idx.
   genvar gi;
   generate
      for (gi = 0; gi < NIBBLES; gi++) begin : g_acc
         assign acc_run[4*gi +: 4] = (idx_q == IW'(gi)) ? slice_sum : acc_q[4*gi +: 4];
      end
   endgenerate

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         opa_q   <= '0;
         opb_q   <= '0;
         c_q     <= 1'b0;
         acc_q   <= '0;
         idx_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         c_q     <= c_d;
         acc_q   <= acc_d;
         idx_q   <= idx_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end

   always_comb begin
      state_d = state_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      c_d     = c_q;
      acc_d   = acc_q;
      idx_d   = idx_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               opa_d   = a_i;
               opb_d   = b_i;
               c_d     = cin_i;
               idx_d   = '0;
               acc_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            acc_d = acc_run;
            c_d   = slice_cout;
            opa_d = opa_q >> 4;
            opb_d = opb_q >> 4;
            idx_d = idx_q + IW'(1);
            // sum/cout only ever see a finished result, never a partial one.
            if (idx_q == LAST_IDX) begin
               sum_d   = acc_run;
               cout_d  = slice_cout;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign ready_o = (state_q == S_IDLE);
   assign busy_o  = (state_q == S_RUN) || (state_q == S_DONE);
   assign done_o  = (state_q == S_DONE);
   assign sum_o   = sum_q;
   assign cout_o  = cout_q;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Bench for nibble_serial_adder_ctrl: a cycle-level reference model checked every cycle,
// plus directed operations with hand-computed results, for NIBBLES=4 and NIBBLES=1.

module tb_nibble_serial_adder_ctrl;
   localparam int N4 = 4;

   logic clk;
   logic rst;

   logic        start4, cin4;
   logic [15:0] a4, b4;
   logic        ready4, busy4, done4, cout4;
   logic [15:0] sum4;

   logic        start1, cin1;
   logic [3:0]  a1, b1;
   logic        ready1, busy1, done1, cout1;
   logic [3:0]  sum1;

   int tests = 0;
   int fails = 0;
   bit check_en = 0;

   nibble_serial_adder_ctrl #(.NIBBLES(4)) u4 (
      .clk_i(clk), .rst_i(rst), .start_i(start4), .a_i(a4), .b_i(b4), .cin_i(cin4),
      .ready_o(ready4), .busy_o(busy4), .done_o(done4), .sum_o(sum4), .cout_o(cout4)
   );

   nibble_serial_adder_ctrl #(.NIBBLES(1)) u1 (
      .clk_i(clk), .rst_i(rst), .start_i(start1), .a_i(a1), .b_i(b1), .cin_i(cin1),
      .ready_o(ready1), .busy_o(busy1), .done_o(done1), .sum_o(sum1), .cout_o(cout1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: phase counts edges since the accepting edge (0 = idle,
   // 1..N4 = nibbles in flight, N4+1 = done cycle); the result is plain a+b+cin.
   int          m_phase = 0;
   logic [16:0] m_pend  = '0;
   logic [15:0] m_sum   = '0;
   logic        m_cout  = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_phase <= 0;
         m_sum   <= '0;
         m_cout  <= 1'b0;
      end else if (m_phase == 0) begin
         if (start4) begin
            m_phase <= 1;
            m_pend  <= {1'b0, a4} + {1'b0, b4} + 17'(cin4);
         end
      end else if (m_phase == N4) begin
         m_phase <= N4 + 1;
         m_sum   <= m_pend[15:0];
         m_cout  <= m_pend[16];
      end else if (m_phase == N4 + 1) begin
         m_phase <= 0;
      end else begin
         m_phase <= m_phase + 1;
      end
   end

   always @(negedge clk) begin
      if (check_en) begin
         chk("model_ready", 32'(ready4), 32'(m_phase == 0));
         chk("model_busy",  32'(busy4),  32'(m_phase != 0));
         chk("model_done",  32'(done4),  32'(m_phase == N4 + 1));
         chk("model_sum",   32'(sum4),   32'(m_sum));
         chk("model_cout",  32'(cout4),  32'(m_cout));
      end
   end

   task automatic wait_ready4();
      int n = 0;
      while (ready4 !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (ready4 !== 1'b1) chk("ready_timeout", 32'(ready4), 32'd1);
   endtask

   task automatic run_op4(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input logic [15:0] exp_sum, input logic exp_cout, input string name);
      int n = 0;
      wait_ready4();
      a4 = a; b4 = b; cin4 = cin; start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      while (n < 40) begin
         @(negedge clk);
         n++;
         if (done4 === 1'b1) break;
      end
      chk({name, "_latency"}, 32'(n), 32'd4);
      chk({name, "_sum"}, 32'(sum4), 32'(exp_sum));
      chk({name, "_cout"}, 32'(cout4), 32'(exp_cout));
      $display("[TB] op a=%h b=%h cin=%0d -> sum=%h cout=%0d after %0d edges", a, b, cin, sum4, cout4, n);
      @(negedge clk);
      chk({name, "_ready_after"}, 32'(ready4), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got running expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int dcount;
      int first_done;
      int second_done;
      int n;

      rst = 1'b1;
      start4 = 1'b1; a4 = 16'hFFFF; b4 = 16'hFFFF; cin4 = 1'b1;
      start1 = 1'b1; a1 = 4'hF;     b1 = 4'hF;     cin1 = 1'b1;
      @(negedge clk);
      check_en = 1;
      @(negedge clk);
      chk("rst_ready", 32'(ready4), 32'd1);
      chk("rst_busy",  32'(busy4),  32'd0);
      chk("rst_done",  32'(done4),  32'd0);
      chk("rst_sum",   32'(sum4),   32'd0);
      chk("rst_cout",  32'(cout4),  32'd0);
      chk("rst1_ready", 32'(ready1), 32'd1);
      $display("[TB] reset: ready=%0d busy=%0d done=%0d sum=%h cout=%0d", ready4, busy4, done4, sum4, cout4);
      rst = 1'b0; start4 = 1'b0; start1 = 1'b0;
      @(negedge clk);

      // NIBBLES=1 instance
      a1 = 4'h9; b1 = 4'h7; cin1 = 1'b1; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      n = 0;
      while (n < 10) begin
         @(negedge clk);
         n++;
         if (done1 === 1'b1) break;
      end
      chk("n1_latency", 32'(n), 32'd1);
      chk("n1_sum",  32'(sum1),  32'h1);
      chk("n1_cout", 32'(cout1), 32'd1);
      chk("n1_busy", 32'(busy1), 32'd1);
      $display("[TB] n1 op a=9 b=7 cin=1 -> sum=%h cout=%0d after %0d edges", sum1, cout1, n);
      @(negedge clk);
      chk("n1_ready_after", 32'(ready1), 32'd1);
      chk("n1_done_after",  32'(done1),  32'd0);

      run_op4(16'h0003, 16'h0001, 1'b0, 16'h0004, 1'b0, "basic");
      run_op4(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, "ripple");
      run_op4(16'h1239, 16'h0877, 1'b1, 16'h1AB1, 1'b0, "mixed");
      run_op4(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, "topcarry");
      run_op4(16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0, "alt");

      // Ignore-while-busy
      wait_ready4();
      a4 = 16'h0001; b4 = 16'h0001; cin4 = 1'b0; start4 = 1'b1;
      @(negedge clk);
      a4 = 16'hFFFF; b4 = 16'hFFFF; start4 = 1'b0;
      dcount = 0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (done4 === 1'b1) begin
            dcount++;
            chk("busy_ignore_sum", 32'(sum4), 32'h0002);
         end
         start4 = (i == 1 || i == 3 || i == 4) ? 1'b1 : 1'b0;
      end
      chk("busy_ignore_dones", 32'(dcount), 32'd1);
      $display("[TB] ignore-while-busy: %0d done pulse(s), sum=%h", dcount, sum4);

      // Back-to-back with start held high
      wait_ready4();
      a4 = 16'h0003; b4 = 16'h0001; cin4 = 1'b0; start4 = 1'b1;
      first_done = -1; second_done = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done4 === 1'b1) begin
            if (first_done < 0) first_done = i;
            else if (second_done < 0) second_done = i;
         end
      end
      start4 = 1'b0;
      chk("b2b_period", 32'(second_done - first_done), 32'd6);
      $display("[TB] back-to-back: done at cycles %0d and %0d", first_done, second_done);

      // Reset mid-operation on the 2nd RUN edge
      wait_ready4();
      @(negedge clk);
      a4 = 16'hFFFF; b4 = 16'h0001; cin4 = 1'b0; start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_ready", 32'(ready4), 32'd1);
      chk("abort_busy",  32'(busy4),  32'd0);
      chk("abort_done",  32'(done4),  32'd0);
      chk("abort_sum",   32'(sum4),   32'd0);
      chk("abort_cout",  32'(cout4),  32'd0);
      dcount = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (done4 === 1'b1) dcount++;
      end
      chk("abort_no_done", 32'(dcount), 32'd0);
      $display("[TB] abort: ready=%0d sum=%h cout=%0d, %0d done pulse(s) after", ready4, sum4, cout4, dcount);
      run_op4(16'h00F0, 16'h0010, 1'b0, 16'h0100, 1'b0, "post_abort");

      @(negedge clk);
      check_en = 0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/nibble_serial_adder_ctrl.md
# nibble_serial_adder_ctrl

Sequencing controller that performs wide additions (4×NIBBLES bits) by time-multiplexing a single 4-bit ripple-carry adder slice, one nibble per clock, LSB nibble first. The slice computes {carry, sum} = a + b + cin. The controller captures operands on a start handshake and walks the slice across the nibbles. It holds the inter-nibble carry in a register and presents the full-width result with a one-cycle done pulse. It sits between the team's wide-arithmetic users and the shared 4-bit adder datapath.

## Interface
- NIBBLES, 4, number of 4-bit slices per operation; legal range 1..16. Operand width W = 4×NIBBLES.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when ready=1.
- a  in  W  operand A; captured at accepted start.
- b  in  W  operand B; captured at accepted start.
- cin  in  1  carry-in to nibble 0; captured at accepted start.
- ready  out  1  high in IDLE only.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse, high in DONE.
- sum  out  W  registered result; holds until next completion.
- cout  out  1  registered carry-out of top nibble; holds with sum.

## Operation
- Internal state: 4-bit slice instance; operand shift registers opa/opb (W bits); carry register c; result accumulator acc (W bits); nibble index idx (ceil(log2(NIBBLES+1)) bits, minimum 1); FSM.
- FSM states:
  - IDLE: ready=1. If start=1: load opa←a, opb←b, c←cin, idx←0, acc←0; go to RUN. Otherwise stay.
  - RUN: slice inputs are opa[3:0], opb[3:0] and c. Each edge places the slice sum into acc nibble idx, sets c←slice carry, shifts opa/opb right by 4 and increments idx. On the edge that processes idx=NIBBLES−1: sum←final acc (including this nibble), cout←slice carry; go to DONE.
  - DONE: done=1 for exactly this cycle; next edge goes to IDLE unconditionally.
- start is ignored in RUN and DONE. Operand changes after capture have no effect.
- Arithmetic: modulo 2^W result plus carry-out; {cout,sum} = a + b + cin exactly, as an unsigned (W+1)-bit value.
- sum/cout change only on the RUN→DONE edge and on reset. Partial results are never visible on sum.
- Reset (any state, including mid-RUN): state←IDLE, ready=1, busy=0, done=0, sum=0, cout=0, c=0, idx=0, acc=0. An aborted operation produces no done pulse.
- rst has priority over start on the same edge.

## Timing
- Edge E0 samples start=1 in IDLE. Edges E1..E_NIBBLES process nibbles 0..NIBBLES−1. After E_NIBBLES: done=1, sum/cout valid. After E_NIBBLES+1: ready=1.
- Latency from start-accepting edge to done: NIBBLES edges (done visible in the cycle following edge E_NIBBLES).
- Minimum start-to-start spacing: NIBBLES+2 cycles. With start held high, back-to-back operations run at that period.
- NIBBLES=1: E1 processes the only nibble; done is visible after E1.
- Outputs are registered; there are no combinational paths from inputs to outputs except none (ready/busy/done decode from the FSM register only).

## Test plan
- Reset: rst=1 for 2 cycles with start=1 -> ready=1, busy=0, done=0, sum=0, cout=0; no operation starts.
- NIBBLES=4, a=16'h0003, b=16'h0001, cin=0 -> done pulse exactly 4 edges after accept, sum=16'h0004, cout=0; ready returns 1 one cycle later.
- Full carry ripple: a=16'hFFFF, b=16'h0000, cin=1 -> sum=16'h0000, cout=1. Also a=16'h1239, b=16'h0877, cin=1 -> sum=16'h1AB1, cout=0.
- Ignore-while-busy: accept a=16'h0001, b=16'h0001, cin=0; pulse start with a=16'hFFFF, b=16'hFFFF during RUN and DONE -> single done with sum=16'h0002. With start held high and operands constant, done pulses every 6 cycles.
- Reset mid-op: assert rst on the 2nd RUN edge -> IDLE next cycle, no done, sum=0, cout=0. Next op a=16'h00F0, b=16'h0010, cin=0 -> sum=16'h0100, cout=0.
- NIBBLES=1 variant: a=4'h9, b=4'h7, cin=1 -> done after 1 edge, sum=4'h1, cout=1.
